// File: rtl/instr_pack.sv
// Shared CPU definitions: data-memory FSM states, default depth and address width.
package instr_pack;

    typedef enum logic [1:0] {DM_IDLE, DM_WAIT, DM_RESP} dmem_state_t;

    localparam int unsigned DMEM_DEPTH = 256;
    localparam int unsigned DMEM_AW    = 8;

endpackage

// File: rtl/data_mem_port_array.sv
// dmem_array: DEPTH x 8 data storage, synchronous write port and registered read port.
module dmem_array
    import instr_pack::*;
#(
    parameter int unsigned DEPTH = DMEM_DEPTH,
    parameter int unsigned AW    = DMEM_AW
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem [DEPTH];
    logic [7:0] rdata_q;
    logic [7:0] rdata_d;

    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem[raddr];
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/data_mem_port.sv
// Data-memory responder for the 9-bit CPU load/store path.
// Optional wait states are compiled in with `define DMEM_WAIT_EN.
module data_mem_port
    import instr_pack::*;
#(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned DEPTH       = DMEM_DEPTH
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       loadEn,
    input  logic       storEn,
    input  logic [7:0] addr,
    input  logic [7:0] storData,
    output logic [7:0] loadData,
    output logic       stall,
    output logic       err
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

`ifdef DMEM_WAIT_EN
    localparam logic [3:0] WAIT_W = 4'(WAIT_CYCLES);
`else
    // WAIT_CYCLES has no effect in this build; DM_WAIT becomes unreachable.
    localparam logic [3:0] WAIT_W = 4'(WAIT_CYCLES) & 4'h0;
`endif

    dmem_state_t state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [7:0]  addr_q, addr_d;
    logic        is_load_q, is_load_d;
    logic        err_q, err_d;

    logic        in_range;
    logic        resp_in_range;
    logic        leave_idle;
    logic        arr_we;
    logic        arr_re;
    logic [7:0]  rd_data;

    dmem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .waddr (addr[AW-1:0]),
        .wdata (storData),
        .re    (arr_re),
        .raddr (addr[AW-1:0]),
        .rdata (rd_data)
    );

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        addr_d        = addr_q;
        is_load_d     = is_load_q;
        err_d         = err_q;
        leave_idle    = 1'b0;
        arr_we        = 1'b0;
        arr_re        = 1'b0;
        in_range      = (32'(addr) < DEPTH);
        resp_in_range = (32'(addr_q) < DEPTH);

        unique case (state_q)
            DM_IDLE: begin
                if (storEn) begin
                    addr_d    = addr;
                    is_load_d = 1'b0;
                    arr_we    = in_range;
                    if (loadEn || !in_range) begin
                        err_d = 1'b1;
                    end
                    // The accept cycle is the first stall cycle, so a store only
                    // needs W-1 cycles in DM_WAIT to stall for W cycles in total.
                    if (WAIT_W > 4'd1) begin
                        state_d    = DM_WAIT;
                        cnt_d      = WAIT_W - 4'd1;
                        leave_idle = 1'b1;
                    end else if (WAIT_W == 4'd1) begin
                        state_d    = DM_RESP;
                        leave_idle = 1'b1;
                    end
                end else if (loadEn) begin
                    addr_d     = addr;
                    is_load_d  = 1'b1;
                    arr_re     = in_range;
                    leave_idle = 1'b1;
                    if (!in_range) begin
                        err_d = 1'b1;
                    end
                    if (WAIT_W != 4'd0) begin
                        state_d = DM_WAIT;
                        cnt_d   = WAIT_W;
                    end else begin
                        state_d = DM_RESP;
                    end
                end
            end
            DM_WAIT: begin
                if (cnt_q <= 4'd1) begin
                    cnt_d   = 4'd0;
                    state_d = DM_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DM_RESP: begin
                state_d = DM_IDLE;
            end
            default: begin
                state_d = DM_IDLE;
            end
        endcase

        // Gated by rst_n so the stall drops the moment reset asserts.
        stall    = rst_n && ((state_q == DM_WAIT) || leave_idle);
        loadData = (state_q == DM_RESP && is_load_q && resp_in_range) ? rd_data : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= DM_IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            is_load_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            is_load_q <= is_load_d;
            err_q     <= err_d;
        end
    end

    assign err = err_q;

endmodule

// File: tb/tb_data_mem_port.sv
// Self-checking bench for data_mem_port: transaction-level model plus directed and random stimulus.
module tb_data_mem_port;

    localparam int unsigned DEPTH  = 128;
`ifdef DMEM_WAIT_EN
    localparam int unsigned W      = 3;
`else
    localparam int unsigned W      = 0;
`endif
    localparam int unsigned BUDGET = 40;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       loadEn;
    logic       storEn;
    logic [7:0] addr;
    logic [7:0] storData;
    logic [7:0] loadData;
    logic       stall;
    logic       err;

    always #5 clk = ~clk;

    data_mem_port #(
        .WAIT_CYCLES (3),
        .DEPTH       (DEPTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .loadEn   (loadEn),
        .storEn   (storEn),
        .addr     (addr),
        .storData (storData),
        .loadData (loadData),
        .stall    (stall),
        .err      (err)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model: memory image, sticky error, and the per-cycle
    // (stall, loadData) schedule of the transaction in flight.
    logic [7:0] mem_m [256];
    bit         q_stall [$];
    logic [7:0] q_data  [$];
    bit         err_m = 1'b0;
    bit         chk_en = 1'b0;
    logic       exp_stall;
    logic       exp_err;
    logic [7:0] exp_data;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s cyc=%0d: got %h want %h", name, cyc, act, want);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("stall",    {7'b0, stall}, {7'b0, exp_stall});
            check("loadData", loadData,      exp_data);
            check("err",      {7'b0, err},   {7'b0, exp_err});
        end
    end

    task automatic step(input logic le, input logic se, input logic [7:0] a, input logic [7:0] d,
                        output logic s, output logic [7:0] ld, output logic e);
        bit busy;
        bit inr;
        loadEn   = le;
        storEn   = se;
        addr     = a;
        storData = d;
        busy = (q_stall.size() != 0);
        if (busy) begin
            exp_stall = q_stall[0];
            exp_data  = q_data[0];
        end else begin
            exp_data  = 8'h00;
            exp_stall = se ? (W > 0) : le;
        end
        exp_err = err_m;
        chk_en  = 1'b1;
        @(negedge clk);
        s  = stall;
        ld = loadData;
        e  = err;
        @(posedge clk);
        cyc++;
        inr = (32'(a) < DEPTH);
        if (busy) begin
            void'(q_stall.pop_front());
            void'(q_data.pop_front());
        end else if (se) begin
            if (le || !inr) err_m = 1'b1;
            if (inr) mem_m[a] = d;
            if (W > 0) begin
                for (int i = 1; i < int'(W); i++) begin
                    q_stall.push_back(1'b1);
                    q_data.push_back(8'h00);
                end
                q_stall.push_back(1'b0);
                q_data.push_back(8'h00);
            end
        end else if (le) begin
            if (!inr) err_m = 1'b1;
            for (int i = 0; i < int'(W); i++) begin
                q_stall.push_back(1'b1);
                q_data.push_back(8'h00);
            end
            q_stall.push_back(1'b0);
            q_data.push_back(inr ? mem_m[a] : 8'h00);
        end
        #1;
    endtask

    // Holds a request until stall is seen low; returns stall-cycle count and final loadData.
    task automatic xact(input logic le, input logic se, input logic [7:0] a, input logic [7:0] d,
                        output int n, output logic [7:0] rd);
        logic       s;
        logic       e;
        logic [7:0] ld;
        n  = 0;
        s  = 1'b1;
        ld = 8'h00;
        for (int i = 0; i < int'(BUDGET) && s; i++) begin
            step(le, se, a, d, s, ld, e);
            if (s) n++;
        end
        total++;
        if (s) begin
            bad++;
            $display("FAIL xact_budget cyc=%0d: got stall=1 after %0d cycles want stall=0", cyc, BUDGET);
        end
        rd = ld;
    endtask

    task automatic pulse_reset(output logic s, output logic [7:0] ld);
        chk_en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        s  = stall;
        ld = loadData;
        loadEn = 1'b0;
        storEn = 1'b0;
        q_stall.delete();
        q_data.delete();
        err_m = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        int         n;
        logic [7:0] rd;
        logic       s;
        logic       e;
        logic [7:0] ld;
        int unsigned r;
        logic [7:0] ra;

        rst_n    = 1'b0;
        loadEn   = 1'b0;
        storEn   = 1'b0;
        addr     = 8'h00;
        storData = 8'h00;
        #1;
        check("reset_stall",    {7'b0, stall}, 8'h00);
        check("reset_loadData", loadData,      8'h00);
        check("reset_err",      {7'b0, err},   8'h00);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        for (int a = 0; a < int'(DEPTH); a++) begin
            xact(1'b0, 1'b1, 8'(a), 8'($urandom), n, rd);
        end

        xact(1'b0, 1'b1, 8'h20, 8'hA5, n, rd);
        check("store_stall_cycles", 8'(n), 8'(W));
        xact(1'b1, 1'b0, 8'h20, 8'h00, n, rd);
        check("load_stall_cycles", 8'(n), 8'(W + 1));
        check("load_20", rd, 8'hA5);

        xact(1'b1, 1'b0, 8'h10, 8'h00, n, rd);
        check("b2b_load10_cycles", 8'(n), 8'(W + 1));
        xact(1'b1, 1'b0, 8'h11, 8'h00, n, rd);
        check("b2b_load11_cycles", 8'(n), 8'(W + 1));
        xact(1'b0, 1'b1, 8'h10, 8'h3C, n, rd);
        xact(1'b1, 1'b0, 8'h10, 8'h00, n, rd);
        check("b2b_load10_new", rd, 8'h3C);

        step(1'b1, 1'b0, 8'h20, 8'h00, s, ld, e);
        check("pre_reset_stall", {7'b0, s}, 8'h01);
        pulse_reset(s, ld);
        check("midreset_stall",    {7'b0, s}, 8'h00);
        check("midreset_loadData", ld,        8'h00);
        step(1'b0, 1'b0, 8'h00, 8'h00, s, ld, e);
        check("post_reset_err", {7'b0, e}, 8'h00);
        xact(1'b1, 1'b0, 8'h20, 8'h00, n, rd);
        check("post_reset_load20", rd, 8'hA5);

        xact(1'b1, 1'b1, 8'h05, 8'h77, n, rd);
        check("both_en_stall_cycles", 8'(n), 8'(W));
        check("both_en_no_data", rd, 8'h00);
        step(1'b0, 1'b0, 8'h00, 8'h00, s, ld, e);
        check("both_en_err", {7'b0, e}, 8'h01);
        xact(1'b1, 1'b0, 8'h05, 8'h00, n, rd);
        check("load_05", rd, 8'h77);

        pulse_reset(s, ld);
        xact(1'b1, 1'b0, 8'h90, 8'h00, n, rd);
        check("oob_load_data", rd, 8'h00);
        step(1'b0, 1'b0, 8'h00, 8'h00, s, ld, e);
        check("oob_err", {7'b0, e}, 8'h01);
        xact(1'b0, 1'b1, 8'h90, 8'hFF, n, rd);
        xact(1'b1, 1'b0, 8'h10, 8'h00, n, rd);
        check("oob_store_no_alias", rd, 8'h3C);

        pulse_reset(s, ld);
        for (int i = 0; i < 2500; i++) begin
            r  = $urandom_range(0, 7);
            ra = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, DEPTH - 1));
            step(r < 3, (r >= 2) && (r < 5), ra, 8'($urandom), s, ld, e);
        end

        step(1'b0, 1'b0, 8'h00, 8'h00, s, ld, e);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/data_mem_port.md
# data_mem_port

Data-memory responder for the 9-bit CPU: it is the memory end of the register file's load/store interface. It accepts the `storEn`/`storData` write path and the `loadEn`/`loadData` read path, holds a 256 x 8 data array, and raises `stall` to freeze the program counter while a load (or a wait-stated access) is outstanding. It sits beside the register file and is driven by the same decode strobes.

## Interface
Parameters:
- `WAIT_CYCLES`, default 2: extra wait states per access (0..15). Used only when `DMEM_WAIT_EN` is defined.
- `DEPTH`, default 256: number of data words. The address width is fixed at 8.

Ports:
- `clk`  in  1  system clock. Everything is on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `loadEn`  in  1  load request. Held high by the CPU until it samples `stall`=0.
- `storEn`  in  1  store request. Held high under the same rule as `loadEn`.
- `addr`  in  8  word address, valid while either enable is high.
- `storData`  in  8  write data. May be `z` when `storEn`=0; it is ignored then.
- `loadData`  out  8  read data. It is valid only in the response cycle and is 0 otherwise.
- `stall`  out  1  high means the CPU must hold its state and its request.
- `err`  out  1  sticky flag for a protocol violation. Cleared only by reset.

## Operation
- The FSM states are `DM_IDLE`, `DM_WAIT`, and `DM_RESP`. The reset state is `DM_IDLE`.
- Reset values: `stall`=0, `loadData`=0, `err`=0, wait counter 0, latched address 0. Array contents are not reset.
- Accepting a request in `DM_IDLE`:
  - `addr` is latched.
  - A store writes `storData` into `array[addr]` at the accept edge. This happens in every configuration.
  - A load registers `array[addr]` into the read buffer at the accept edge.
- Next-state rules:
  - `DM_IDLE` with `loadEn` goes to `DM_WAIT` if the wait counter is armed, otherwise to `DM_RESP`.
  - `DM_IDLE` with `storEn` goes to `DM_WAIT` if `DMEM_WAIT_EN` is defined and `WAIT_CYCLES`>0. Otherwise it stays in `DM_IDLE`.
  - `DM_WAIT` decrements the counter and goes to `DM_RESP` when the counter reaches 1.
  - `DM_RESP` always returns to `DM_IDLE`.
- Output rules:
  - `stall` = 1 in `DM_WAIT`.
  - `stall` = 1 in `DM_IDLE` when a request that will leave `DM_IDLE` is present. This term is combinational from the enables.
  - `stall` = 0 in `DM_RESP`.
  - `loadData` drives the read buffer only in `DM_RESP` of a load transaction.
- Requests seen in `DM_WAIT` or `DM_RESP` are the held copy of the current request and are ignored.
- Back-to-back requests are accepted only from `DM_IDLE`. A new request in the cycle after `DM_RESP` starts a new transaction.
- `loadEn` and `storEn` high together is an illegal condition:
  - the store wins and the load is dropped;
  - `err` is set at that edge.
- Out-of-range address (`addr` >= `DEPTH`):
  - stores are discarded;
  - loads return 0;
  - `err` is set.
- Reset asserted mid-transaction forces `DM_IDLE` immediately:
  - `stall` and `loadData` drop asynchronously;
  - a store already committed stays in the array;
  - a pending load is lost.

## Timing
- Load without waits: `loadEn` rises in cycle N, so `stall`=1 in N. In N+1 (`DM_RESP`), `stall`=0 and `loadData` is valid. The register file captures at the end of N+1. Latency is 1 cycle.
- Load with waits (W = `WAIT_CYCLES`): `stall` is high for cycles N..N+W. `DM_RESP` is cycle N+1+W.
- Store without waits: 0-cycle stall. The array is updated at the end of cycle N, and a load in N+1 sees the new value.
- Store with waits: `stall` is high for W cycles (N..N+W-1). The data is already committed at the end of N.
- Read-during-write is not possible, because requests are accepted one per `DM_IDLE` cycle.

## Configuration
- Macro: `DMEM_WAIT_EN`.
- Defined: the wait counter and the `DM_WAIT` state are compiled in, and both loads and stores incur `WAIT_CYCLES` wait states.
- Undefined: `DM_WAIT` is removed and `WAIT_CYCLES` is ignored. Loads always take 1 stall cycle and stores take none.

## Structure
- Add to `instr_pack`:
  - `typedef enum logic [1:0] {DM_IDLE, DM_WAIT, DM_RESP} dmem_state_t`;
  - constant `DMEM_DEPTH` = 256.
- Sub-module `dmem_array`: `DEPTH` x 8 storage with a synchronous write port and a registered read port.
- All control logic stays in `data_mem_port`: FSM, counter, stall logic, and the error flag.

## Test plan
- Without the macro: store `addr`=8'h20, `storData`=8'hA5 for one cycle. Then load 8'h20. Expect `stall`=1 for one cycle, then `loadData`=8'hA5 with `stall`=0.
- With the macro, W=3: load 8'h20. Expect `stall` high for exactly 4 cycles, then one `DM_RESP` cycle with 8'hA5. `loadData`=0 in all other cycles.
- Back-to-back transactions: load 8'h10, load 8'h11, then store 8'h10=8'h3C, then load 8'h10. Expect each load accepted only from `DM_IDLE` and a final read of 8'h3C.
- Assert `loadEn` and `storEn` together with `addr`=8'h05 and `storData`=8'h77. Expect `err`=1, `array[5]`=8'h77, and no `DM_RESP` load cycle.
- Drop `rst_n` during `DM_WAIT` of a load. Expect `stall`=0 and `loadData`=0 immediately. After release, expect the FSM in `DM_IDLE` and previously stored data intact.
- With `DEPTH`=128: load 8'h90. Expect `loadData`=0 and `err`=1. Store 8'h90=8'hFF, then load 8'h10. Expect the value at 8'h10 unchanged.
